// File: rtl/mips32_bus_core.sv
// Multicycle MIPS32 integer core with one Avalon-MM-style master port shared by fetch and data.
// Define BYTE_HALF_ACCESS_EN to add LB/LBU/LH/LHU/SB/SH; otherwise those opcodes are NOPs.
module mips32_bus_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [31:0] register_v0
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e      state_q;
  logic [31:0] regs [32];
  logic [31:0] pc_q, npc_q, ir_q, a_q, b_q, res_q, tgt_q;
  logic [4:0]  dst_q;
  logic        wen_q, taken_q, ld_sign_q;
  logic [1:0]  ld_size_q, lane_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext, zext, ea, pc4;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];
  assign sext  = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext  = {16'h0, ir_q[15:0]};
  assign ea    = a_q + sext;
  assign pc4   = pc_q + 32'd4;

  assign register_v0 = regs[2];

  // Execute-stage decode: ALU result, writeback target, control flow and memory request.
  logic [31:0] alu, tgt, st_data;
  logic [4:0]  dst;
  logic        wen, taken, is_ld, is_st, ld_sign;
  logic [1:0]  ld_size;
  logic [3:0]  be;

  always_comb begin
    alu     = '0;
    tgt     = '0;
    st_data = b_q;
    dst     = rt;
    wen     = 1'b0;
    taken   = 1'b0;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    ld_sign = 1'b0;
    ld_size = 2'd2;
    be      = 4'hF;
    case (op)
      6'h00: begin
        dst = rd;
        wen = 1'b1;
        case (funct)
          6'h21: alu = a_q + b_q;
          6'h23: alu = a_q - b_q;
          6'h24: alu = a_q & b_q;
          6'h25: alu = a_q | b_q;
          6'h26: alu = a_q ^ b_q;
          6'h2A: alu = {31'b0, $signed(a_q) < $signed(b_q)};
          6'h2B: alu = {31'b0, a_q < b_q};
          6'h00: alu = b_q << shamt;
          6'h02: alu = b_q >> shamt;
          6'h03: alu = $signed(b_q) >>> shamt;
          6'h08: begin
            wen   = 1'b0;
            taken = 1'b1;
            tgt   = a_q;
          end
          6'h09: begin
            taken = 1'b1;
            tgt   = a_q;
            alu   = pc_q + 32'd8;
          end
          default: wen = 1'b0;
        endcase
      end
      6'h09: begin alu = a_q + sext; wen = 1'b1; end
      6'h0A: begin alu = {31'b0, $signed(a_q) < $signed(sext)}; wen = 1'b1; end
      6'h0B: begin alu = {31'b0, a_q < sext}; wen = 1'b1; end
      6'h0C: begin alu = a_q & zext; wen = 1'b1; end
      6'h0D: begin alu = a_q | zext; wen = 1'b1; end
      6'h0E: begin alu = a_q ^ zext; wen = 1'b1; end
      6'h0F: begin alu = {ir_q[15:0], 16'h0}; wen = 1'b1; end
      6'h04: begin taken = (a_q == b_q); tgt = pc4 + (sext << 2); end
      6'h05: begin taken = (a_q != b_q); tgt = pc4 + (sext << 2); end
      6'h06: begin taken = ($signed(a_q) <= 32'sd0); tgt = pc4 + (sext << 2); end
      6'h07: begin taken = ($signed(a_q) > 32'sd0); tgt = pc4 + (sext << 2); end
      6'h02: begin taken = 1'b1; tgt = {pc4[31:28], ir_q[25:0], 2'b00}; end
      6'h03: begin
        taken = 1'b1;
        tgt   = {pc4[31:28], ir_q[25:0], 2'b00};
        alu   = pc_q + 32'd8;
        dst   = 5'd31;
        wen   = 1'b1;
      end
      6'h23: begin is_ld = 1'b1; wen = 1'b1; end
      6'h2B: is_st = 1'b1;
`ifdef BYTE_HALF_ACCESS_EN
      6'h20, 6'h24: begin
        is_ld   = 1'b1;
        wen     = 1'b1;
        ld_size = 2'd0;
        ld_sign = (op == 6'h20);
        be      = 4'b0001 << ea[1:0];
      end
      6'h21, 6'h25: begin
        // Misaligned halfword: no bus access, no writeback.
        if (!ea[0]) begin
          is_ld   = 1'b1;
          wen     = 1'b1;
          ld_size = 2'd1;
          ld_sign = (op == 6'h21);
          be      = 4'b0011 << ea[1:0];
        end
      end
      6'h28: begin
        is_st   = 1'b1;
        be      = 4'b0001 << ea[1:0];
        st_data = {4{b_q[7:0]}};
      end
      6'h29: begin
        if (!ea[0]) begin
          is_st   = 1'b1;
          be      = 4'b0011 << ea[1:0];
          st_data = {2{b_q[15:0]}};
        end
      end
`endif
      default: ;
    endcase
  end

  // Load lane extraction; for word loads this is readdata unchanged.
  logic [31:0] lane_data, ld_val;

  always_comb begin
    lane_data = readdata >> {lane_q, 3'b000};
    case (ld_size_q)
      2'd0:    ld_val = ld_sign_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                  : {24'h0, lane_data[7:0]};
      2'd1:    ld_val = ld_sign_q ? {{16{lane_data[15]}}, lane_data[15:0]}
                                  : {16'h0, lane_data[15:0]};
      default: ld_val = readdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StFetch;
      pc_q       <= RESET_VECTOR;
      npc_q      <= RESET_VECTOR + 32'd4;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      tgt_q      <= '0;
      dst_q      <= '0;
      wen_q      <= 1'b0;
      taken_q    <= 1'b0;
      ld_sign_q  <= 1'b0;
      ld_size_q  <= 2'd2;
      lane_q     <= '0;
      active     <= 1'b1;
      address    <= RESET_VECTOR;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      unique case (state_q)
        StFetch: begin
          if (!read) begin
            // Only reached straight out of reset; WB normally pre-arms the fetch.
            read       <= 1'b1;
            address    <= pc_q;
            byteenable <= 4'hF;
          end else if (!waitrequest) begin
            ir_q       <= readdata;
            read       <= 1'b0;
            byteenable <= '0;
            state_q    <= StDecode;
          end
        end
        StDecode: begin
          a_q     <= regs[rs];
          b_q     <= regs[rt];
          state_q <= StExec;
        end
        StExec: begin
          res_q     <= alu;
          dst_q     <= dst;
          wen_q     <= wen;
          taken_q   <= taken;
          tgt_q     <= tgt;
          ld_size_q <= ld_size;
          ld_sign_q <= ld_sign;
          lane_q    <= ea[1:0];
          if (is_ld || is_st) begin
            address    <= {ea[31:2], 2'b00};
            read       <= is_ld;
            write      <= is_st;
            byteenable <= be;
            writedata  <= st_data;
            state_q    <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (!waitrequest) begin
            if (read) res_q <= ld_val;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            state_q    <= StWb;
          end
        end
        StWb: begin
          if (wen_q && dst_q != 5'd0) regs[dst_q] <= res_q;
          pc_q  <= npc_q;
          npc_q <= taken_q ? tgt_q : npc_q + 32'd4;
          if (npc_q == 32'h0) begin
            active  <= 1'b0;
            state_q <= StHalt;
          end else begin
            read       <= 1'b1;
            address    <= npc_q;
            byteenable <= 4'hF;
            state_q    <= StFetch;
          end
        end
        StHalt: ;
        default: state_q <= StHalt;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_bus_core.sv
// Self-checking bench for mips32_bus_core: small programs run from a word RAM at 0xBFC00000,
// expected $v0 values and store transactions queued up front and checked as the core produces them.
module tb_mips32_bus_core;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        active, write, read;
  logic        waitrequest = 1'b0;
  logic [31:0] address, writedata, readdata, register_v0;
  logic [3:0]  byteenable;

  int total = 0;
  int bad = 0;

  logic [31:0] mem [256];
  logic [31:0] exp_v0 [$];
  logic [67:0] exp_st [$];

  mips32_bus_core #(.RESET_VECTOR(RV)) dut (
    .clk        (clk),
    .reset      (reset),
    .active     (active),
    .address    (address),
    .write      (write),
    .read       (read),
    .waitrequest(waitrequest),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata),
    .register_v0(register_v0)
  );

  always #5 clk = ~clk;

  assign readdata = mem[address[9:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jr(input logic [4:0] rs);
    return {6'h00, rs, 15'h0, 6'h08};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic load_prog_v0();
    clear_mem();
    mem[0] = it(6'h0F, 5'd0, 5'd2, 16'h1234);  // LUI  $2,0x1234
    mem[1] = it(6'h0D, 5'd2, 5'd2, 16'h5678);  // ORI  $2,$2,0x5678
    mem[2] = jr(5'd0);
    mem[3] = 32'h0;
  endtask

  task automatic run_prog(input int stall_at, input int budget);
    int          rd_cnt = 0;
    int          zero_hits = 0;
    int          post_bus = 0;
    logic        halted = 1'b0;
    logic        stalled = 1'b0;
    logic [31:0] saddr, v0_seen;
    logic [67:0] st;
    waitrequest = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_read", read, 1'b0);
    chk("rst_write", write, 1'b0);
    chk("rst_be", byteenable, 4'h0);
    chk("rst_addr", address, RV);
    chk("rst_active", active, 1'b1);
    chk("rst_v0", register_v0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("first_read", read, 1'b1);
        chk("first_addr", address, RV);
        chk("first_be", byteenable, 4'hF);
        chk("first_active", active, 1'b1);
      end
      if (!active) begin
        halted = 1'b1;
        break;
      end
      if (stall_at >= 0 && !stalled && read && rd_cnt == stall_at) begin
        saddr = address;
        waitrequest = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_addr", address, saddr);
          chk("stall_read", read, 1'b1);
          chk("stall_be", byteenable, 4'hF);
        end
        waitrequest = 1'b0;
        stalled = 1'b1;
      end
      if (read && write) chk("rw_both", 1'b1, 1'b0);
      if ((read || write) && address == 32'h0) zero_hits++;
      if (read && !waitrequest) rd_cnt++;
      if (write && !waitrequest) begin
        for (int i = 0; i < 4; i++)
          if (byteenable[i]) mem[address[9:2]][8*i +: 8] = writedata[8*i +: 8];
        if (exp_st.size() == 0) begin
          chk("st_unexp", 1'b1, 1'b0);
        end else begin
          st = exp_st.pop_front();
          chk("st_addr", address, st[67:36]);
          chk("st_data", writedata, st[35:4]);
          chk("st_be", byteenable, st[3:0]);
        end
      end
    end
    chk("halted", halted, 1'b1);
    if (exp_v0.size() == 0) chk("v0_noexp", 1'b1, 1'b0);
    else chk("v0", register_v0, exp_v0.pop_front());
    chk("addr0", zero_hits, 0);
    chk("st_left", exp_st.size(), 0);
    v0_seen = register_v0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (read || write) post_bus++;
    end
    chk("post_halt_bus", post_bus, 0);
    chk("post_halt_v0", register_v0, v0_seen);
    chk("post_halt_active", active, 1'b0);
  endtask

  initial begin
    // Straight-line LUI/ORI then JR $0 halt; also covers reset and first fetch.
    load_prog_v0();
    exp_v0.push_back(32'h12345678);
    run_prog(-1, 300);

    // Same program with the third fetch stalled for five cycles.
    load_prog_v0();
    exp_v0.push_back(32'h12345678);
    run_prog(2, 300);

    // SW then LW through a base register.
    clear_mem();
    mem[0] = it(6'h0F, 5'd0, 5'd3, 16'hBFC0);  // LUI   $3,0xBFC0
    mem[1] = it(6'h0F, 5'd0, 5'd2, 16'hDEAD);  // LUI   $2,0xDEAD
    mem[2] = it(6'h0D, 5'd2, 5'd2, 16'hBEEF);  // ORI   $2,$2,0xBEEF
    mem[3] = it(6'h2B, 5'd3, 5'd2, 16'h0100);  // SW    $2,0x100($3)
    mem[4] = it(6'h09, 5'd0, 5'd2, 16'h0000);  // ADDIU $2,$0,0
    mem[5] = it(6'h23, 5'd3, 5'd2, 16'h0100);  // LW    $2,0x100($3)
    mem[6] = jr(5'd0);
    mem[7] = 32'h0;
    exp_st.push_back({32'hBFC00100, 32'hDEADBEEF, 4'hF});
    exp_v0.push_back(32'hDEADBEEF);
    run_prog(-1, 400);

    // Taken BEQ: delay slot runs, the skipped ADDIU 100 does not.
    clear_mem();
    mem[0] = it(6'h09, 5'd0, 5'd2, 16'h0000);  // ADDIU $2,$0,0
    mem[1] = it(6'h04, 5'd0, 5'd0, 16'h0002);  // BEQ   $0,$0,+2
    mem[2] = it(6'h09, 5'd2, 5'd2, 16'h0001);  // ADDIU $2,$2,1 (delay slot)
    mem[3] = it(6'h09, 5'd2, 5'd2, 16'h0064);  // ADDIU $2,$2,100 (skipped)
    mem[4] = it(6'h09, 5'd2, 5'd2, 16'h0002);  // ADDIU $2,$2,2 (target)
    mem[5] = jr(5'd0);
    mem[6] = 32'h0;
    exp_v0.push_back(32'h00000003);
    run_prog(-1, 400);

    // Negative ADDIU wraps; SLT sees it as smaller than 1.
    clear_mem();
    mem[0] = it(6'h09, 5'd0, 5'd4, 16'hFFFF);                   // ADDIU $4,$0,-1
    mem[1] = it(6'h09, 5'd0, 5'd5, 16'h0001);                   // ADDIU $5,$0,1
    mem[2] = {6'h00, 5'd4, 5'd5, 5'd2, 5'd0, 6'h2A};             // SLT   $2,$4,$5
    mem[3] = {6'h00, 5'd4, 5'd5, 5'd6, 5'd0, 6'h2B};             // SLTU  $6,$4,$5
    mem[4] = {6'h00, 5'd2, 5'd6, 5'd2, 5'd0, 6'h21};             // ADDU  $2,$2,$6
    mem[5] = jr(5'd0);
    mem[6] = 32'h0;
    exp_v0.push_back(32'h00000001);
    run_prog(-1, 400);

`ifdef BYTE_HALF_ACCESS_EN
    // Byte store to lane 3, then sign-extending byte load.
    clear_mem();
    mem[0] = it(6'h0F, 5'd0, 5'd3, 16'hBFC0);  // LUI   $3,0xBFC0
    mem[1] = it(6'h09, 5'd0, 5'd2, 16'h0080);  // ADDIU $2,$0,0x80
    mem[2] = it(6'h28, 5'd3, 5'd2, 16'h0103);  // SB    $2,0x103($3)
    mem[3] = it(6'h20, 5'd3, 5'd2, 16'h0103);  // LB    $2,0x103($3)
    mem[4] = jr(5'd0);
    mem[5] = 32'h0;
    exp_st.push_back({32'hBFC00100, 32'h80808080, 4'b1000});
    exp_v0.push_back(32'hFFFFFF80);
    run_prog(-1, 400);
`endif

    // Asynchronous reset in the middle of a stalled fetch drops the strobe at once.
    load_prog_v0();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_async_read", read, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_read", read, 1'b0);
    chk("async_addr", address, RV);
    chk("async_active", active, 1'b1);
    waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
